// File: rtl/exercise_name_streamer.sv
// exercise_name_streamer
//   Looks up an exercise name from an internal table and streams it one ASCII
//   byte per valid/ready handshake, leftmost character first.
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   start, index request a name; sampled only while idle
//   busy         high from the cycle after start is accepted through the done cycle
//   char_out     current byte (8'h00 whenever char_valid is low)
//   char_valid   char_out holds a byte for the sink
//   char_ready   sink accepts char_out when char_valid && char_ready
//   char_last    marks the final byte of the name
//   done         one-cycle pulse after the final byte is accepted
//   bad_index    the current/last request used an index >= NUM_EXERCISES
module exercise_name_streamer #(
  parameter int unsigned NAME_CHARS    = 16,
  parameter int unsigned NUM_EXERCISES = 8,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned TRIM_SPACES   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] index,
  output logic             busy,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             char_last,
  output logic             done,
  output logic             bad_index
);

  localparam int unsigned POS_W     = $clog2(NAME_CHARS + 1);
  localparam int unsigned BUF_W     = 8 * NAME_CHARS;
  localparam int unsigned RAW_CHARS = 14;
  localparam int unsigned RAW_W     = 8 * RAW_CHARS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] len_q, len_d;

  logic             busy_d;
  logic [7:0]       char_out_d;
  logic             char_valid_d;
  logic             char_last_d;
  logic             done_d;
  logic             bad_index_d;

  logic             idx_bad_c;
  logic [RAW_W-1:0] raw_c;
  logic [BUF_W-1:0] name_c;
  logic [POS_W-1:0] len_c;
  logic             at_last_c;

  // Out-of-range check on the latched index
  assign idx_bad_c = (32'(idx_q) >= NUM_EXERCISES);

  // Name table: 14-char literals, first character in the top byte
  always_comb begin
    raw_c = "Unknown       ";
    if (!idx_bad_c) begin
      case (32'(idx_q))
        32'd0:   raw_c = "Jumping Jacks ";
        32'd1:   raw_c = "Push Ups      ";
        32'd2:   raw_c = "Squats        ";
        32'd3:   raw_c = "Lunges        ";
        32'd4:   raw_c = "Plank         ";
        32'd5:   raw_c = "Mountain Climb";
        32'd6:   raw_c = "Burpees       ";
        32'd7:   raw_c = "High Knees    ";
        default: raw_c = "Unknown       ";
      endcase
    end
  end

  // Re-pack so byte position i (0 = leftmost char) sits at bits [8*i +: 8], space padded
  always_comb begin
    name_c = {NAME_CHARS{8'h20}};
    for (int unsigned i = 0; i < RAW_CHARS; i++) begin
      name_c[8*i +: 8] = raw_c[8*(RAW_CHARS-1-i) +: 8];
    end
  end

  // Stream length: full padded width, or up to and including the last non-space char
  always_comb begin
    len_c = '0;
    for (int unsigned i = 0; i < NAME_CHARS; i++) begin
      if ((TRIM_SPACES == 0) || (name_c[8*i +: 8] != 8'h20)) begin
        len_c = POS_W'(i + 1);
      end
    end
  end

  assign at_last_c = (pos_q == (len_q - POS_W'(1)));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    pos_d        = pos_q;
    len_d        = len_q;
    busy_d       = 1'b0;
    char_out_d   = 8'h00;
    char_valid_d = 1'b0;
    char_last_d  = 1'b0;
    done_d       = 1'b0;
    bad_index_d  = bad_index;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d       = index;
          bad_index_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        buf_d        = name_c;
        len_d        = len_c;
        pos_d        = '0;
        bad_index_d  = idx_bad_c;
        busy_d       = 1'b1;
        char_valid_d = 1'b1;
        char_out_d   = name_c[7:0];
        char_last_d  = (len_c == POS_W'(1));
        state_d      = S_SEND;
      end

      S_SEND: begin
        busy_d       = 1'b1;
        char_valid_d = 1'b1;
        char_out_d   = buf_q[7:0];
        char_last_d  = at_last_c;
        if (char_ready) begin
          if (at_last_c) begin
            char_valid_d = 1'b0;
            char_out_d   = 8'h00;
            char_last_d  = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end else begin
            // Shift the next character into the low byte
            pos_d       = pos_q + POS_W'(1);
            buf_d       = buf_q >> 8;
            char_out_d  = buf_q[15:8];
            char_last_d = ((pos_q + POS_W'(2)) == len_q);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      pos_q      <= '0;
      len_q      <= '0;
      busy       <= 1'b0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      done       <= 1'b0;
      bad_index  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      busy       <= busy_d;
      char_out   <= char_out_d;
      char_valid <= char_valid_d;
      char_last  <= char_last_d;
      done       <= done_d;
      bad_index  <= bad_index_d;
    end
  end

endmodule

// File: tb/tb_exercise_name_streamer.sv
// Bench for exercise_name_streamer: two instances (trimmed/8 entries and
// untrimmed/6 entries) share one stimulus stream; every cycle both are compared
// against a queue-style behavioural model, and table-driven requests check the
// received strings, last/done placement and bad_index.
module tb_exercise_name_streamer;

  localparam int NC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       char_ready = 1'b0;
  logic [2:0] index = 3'd0;

  logic       busy_a, valid_a, last_a, done_a, bad_a;
  logic [7:0] char_a;
  logic       busy_b, valid_b, last_b, done_b, bad_b;
  logic [7:0] char_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exercise_name_streamer #(
    .NAME_CHARS(16), .NUM_EXERCISES(8), .IDX_W(3), .TRIM_SPACES(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .index(index),
    .busy(busy_a), .char_out(char_a), .char_valid(valid_a),
    .char_ready(char_ready), .char_last(last_a), .done(done_a),
    .bad_index(bad_a)
  );

  exercise_name_streamer #(
    .NAME_CHARS(16), .NUM_EXERCISES(6), .IDX_W(3), .TRIM_SPACES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .index(index),
    .busy(busy_b), .char_out(char_b), .char_valid(valid_b),
    .char_ready(char_ready), .char_last(last_b), .done(done_b),
    .bad_index(bad_b)
  );

  // ---------------- behavioural model ----------------
  int         m_num  [2] = '{8, 6};
  bit         m_trim [2] = '{1'b1, 1'b0};
  int         m_phase[2] = '{0, 0};   // 0 idle, 1 load, 2 streaming, 3 done
  int         m_idx  [2] = '{0, 0};
  int         m_head [2] = '{0, 0};
  int         m_len  [2] = '{0, 0};
  bit         m_bad  [2] = '{1'b0, 1'b0};
  logic [7:0] m_buf  [2][NC];

  function automatic string name_of(int idx, int num);
    if (idx >= num) return "Unknown";
    case (idx)
      0: return "Jumping Jacks";
      1: return "Push Ups";
      2: return "Squats";
      3: return "Lunges";
      4: return "Plank";
      5: return "Mountain Climb";
      6: return "Burpees";
      7: return "High Knees";
      default: return "Unknown";
    endcase
  endfunction

  always @(posedge clk) begin : model
    string s;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_phase[i] = 0;
        m_bad[i]   = 1'b0;
      end else begin
        case (m_phase[i])
          0: if (start) begin
               m_phase[i] = 1;
               m_bad[i]   = 1'b0;
               m_idx[i]   = int'(index);
             end
          1: begin
               s = name_of(m_idx[i], m_num[i]);
               for (int k = 0; k < NC; k++)
                 m_buf[i][k] = (k < s.len()) ? 8'(s[k]) : 8'h20;
               m_len[i]   = m_trim[i] ? s.len() : NC;
               m_head[i]  = 0;
               m_bad[i]   = (m_idx[i] >= m_num[i]);
               m_phase[i] = 2;
             end
          2: if (char_ready) begin
               m_head[i] = m_head[i] + 1;
               if (m_head[i] == m_len[i]) m_phase[i] = 3;
             end
          default: m_phase[i] = 0;
        endcase
      end
    end
  end

  // {busy, valid, last, done, bad_index, char_out}
  function automatic logic [12:0] expect_vec(int i);
    logic v;
    v = (m_phase[i] == 2);
    return {(m_phase[i] != 0), v, (v && (m_head[i] == m_len[i] - 1)),
            (m_phase[i] == 3), m_bad[i], (v ? m_buf[i][m_head[i]] : 8'h00)};
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", name, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("cycle_a", 32'({busy_a, valid_a, last_a, done_a, bad_a, char_a}), 32'(expect_vec(0)));
    chk("cycle_b", 32'({busy_b, valid_b, last_b, done_b, bad_b, char_b}), 32'(expect_vec(1)));
  end

  // ---------------- request driver ----------------
  string r_a, r_b;
  int    la, lb, nla, nlb, da, db, fva, fvb;
  bit    r_to;

  // mode 0: ready=1; mode 1: ready 1,0,0,1,...; mode 2: ready=1 plus a start pulse mid-stream
  task automatic run_req(input logic [2:0] idx, input int mode);
    int na, nb;
    r_a = ""; r_b = "";
    la = -1; lb = -1; nla = 0; nlb = 0; da = 0; db = 0; fva = -1; fvb = -1;
    na = 0; nb = 0; r_to = 1'b1;
    @(negedge clk);
    start = 1'b1; index = idx; char_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start      = (mode == 2 && c == 5);
      index      = (mode == 2 && c == 5) ? 3'd3 : idx;
      char_ready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (valid_a && fva < 0) fva = c;
      if (valid_b && fvb < 0) fvb = c;
      if (valid_a && char_ready) begin
        r_a = $sformatf("%s%c", r_a, char_a);
        if (last_a) begin la = na; nla++; end
        na++;
      end
      if (valid_b && char_ready) begin
        r_b = $sformatf("%s%c", r_b, char_b);
        if (last_b) begin lb = nb; nlb++; end
        nb++;
      end
      if (done_a) da++;
      if (done_b) db++;
      if (da > 0 && db > 0) begin
        r_to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    char_ready = 1'b1;
  endtask

  typedef struct {
    logic [2:0] idx;
    string      exp_a;
    bit         bad_a;
    string      exp_b;
    bit         bad_b;
  } vec_t;

  vec_t tbl[8];

  task automatic check_req(input int t, input string tag);
    chk("timeout", 32'(r_to), 32'(0));
    chk_str({tag, "_name_a"}, r_a, tbl[t].exp_a);
    chk_str({tag, "_name_b"}, r_b, tbl[t].exp_b);
    chk({tag, "_bad_a"}, 32'(bad_a), 32'(tbl[t].bad_a));
    chk({tag, "_bad_b"}, 32'(bad_b), 32'(tbl[t].bad_b));
    chk({tag, "_last_a"}, 32'(la), 32'(tbl[t].exp_a.len() - 1));
    chk({tag, "_last_b"}, 32'(lb), 32'(tbl[t].exp_b.len() - 1));
    chk({tag, "_nlast"}, 32'(nla + nlb), 32'(2));
    chk({tag, "_done"}, 32'(da + db), 32'(2));
    chk({tag, "_first_valid"}, 32'({fva[7:0], fvb[7:0]}), 32'(16'h0101));
  endtask

  initial begin
    tbl[0] = '{3'd0, "Jumping Jacks",  1'b0, "Jumping Jacks   ", 1'b0};
    tbl[1] = '{3'd1, "Push Ups",       1'b0, "Push Ups        ", 1'b0};
    tbl[2] = '{3'd2, "Squats",         1'b0, "Squats          ", 1'b0};
    tbl[3] = '{3'd3, "Lunges",         1'b0, "Lunges          ", 1'b0};
    tbl[4] = '{3'd4, "Plank",          1'b0, "Plank           ", 1'b0};
    tbl[5] = '{3'd5, "Mountain Climb", 1'b0, "Mountain Climb  ", 1'b0};
    tbl[6] = '{3'd6, "Burpees",        1'b0, "Unknown         ", 1'b1};
    tbl[7] = '{3'd7, "High Knees",     1'b0, "Unknown         ", 1'b1};

    // Reset for two cycles with start held: must not be accepted
    rst = 1'b1; start = 1'b1; index = 3'd2; char_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_a", 32'({busy_a, valid_a, last_a, done_a, bad_a, char_a}), 32'(0));
    chk("reset_b", 32'({busy_b, valid_b, last_b, done_b, bad_b, char_b}), 32'(0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'({busy_a, busy_b}), 32'(0));

    // Table-driven requests with ready held high
    for (int t = 0; t < 8; t++) begin
      run_req(tbl[t].idx, 0);
      check_req(t, $sformatf("tbl%0d", t));
    end

    // Out-of-range index then an in-range one clears bad_index
    run_req(3'd7, 0);
    check_req(7, "bad_then");
    @(negedge clk);
    start = 1'b1; index = 3'd0;
    @(negedge clk);
    start = 1'b0;
    chk("bad_cleared_b", 32'(bad_b), 32'(0));
    repeat (20) @(negedge clk);

    // Backpressure: ready pattern 1,0,0,1
    run_req(3'd5, 1);
    check_req(5, "backpressure");

    // Start during an active stream is ignored
    run_req(3'd0, 2);
    check_req(0, "start_busy");

    // Reset while the third byte is presented
    @(negedge clk);
    start = 1'b1; index = 3'd0; char_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("third_byte", 32'(char_a), 32'(8'h6D));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_a", 32'({busy_a, valid_a, done_a, char_a}), 32'(0));
    chk("abort_b", 32'({busy_b, valid_b, done_b, char_b}), 32'(0));
    da = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_a || done_b) da++;
    end
    chk("no_done_after_abort", 32'(da), 32'(0));
    run_req(3'd1, 0);
    check_req(1, "after_abort");

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 149) == 0);
      start      = ($urandom_range(0, 3) == 0);
      index      = 3'($urandom_range(0, 7));
      char_ready = ($urandom_range(0, 9) < 7);
    end
    rst = 1'b0; start = 1'b0; char_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
